// File: rtl/pkg_ram.sv
// pkg_ram: byte type shared by the UART receiver and the hex loader RAM path
package pkg_ram;
   typedef logic [7:0] RAM_BYTE;
endpackage

// File: rtl/dev_uart_rx.sv
// dev_uart_rx: fixed-baud 8N1 receiver producing one-cycle byte strobes for the hex loader
module dev_uart_rx #(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 115200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   output pkg_ram::RAM_BYTE data_out,
   output logic             data_en,
   output logic             frame_err,
   output logic             busy
);
   localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   generate
      if (CLK_FREQ / BAUD < 8) begin : g_baud_check
         $error("dev_uart_rx: CLK_FREQ/BAUD must be at least 8");
      end
   endgenerate
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t          state;
   logic            rx_m, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   pkg_ram::RAM_BYTE shift;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         data_out  <= '0;
         data_en   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_m      <= rx;
         rx_s      <= rx_m;
         data_en   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               cnt <= cnt == HALF ? '0 : cnt + CW'(1);
               idx <= '0;
               if (cnt == HALF) state <= rx_s ? IDLE : DATA;
            end
            DATA: begin
               cnt <= cnt == LAST ? '0 : cnt + CW'(1);
               if (cnt == LAST) begin
                  shift[idx] <= rx_s;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               cnt <= cnt == LAST ? '0 : cnt + CW'(1);
               if (cnt == LAST) begin
                  data_out  <= rx_s ? shift : data_out;
                  data_en   <= rx_s;
                  frame_err <= !rx_s;
                  state     <= rx_s ? IDLE : BREAK;
               end
            end
            // a held-low line stays here so a break reports only one frame_err
            BREAK: if (rx_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dev_uart_rx.sv
// tb_dev_uart_rx: random and directed frames on a 104-clock and an 8-clock receiver against a frame-level model
module tb_dev_uart_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx0 = 1'b1;
   logic rx1 = 1'b1;
   pkg_ram::RAM_BYTE do0, do1;
   logic en0, en1, fe0, fe1, bz0, bz1;
   always #5 clk = ~clk;
   dev_uart_rx dut0 (
      .clk(clk), .rst(rst), .rx(rx0),
      .data_out(do0), .data_en(en0), .frame_err(fe0), .busy(bz0)
   );
   dev_uart_rx #(.CLK_FREQ(1600000), .BAUD(200000)) dut1 (
      .clk(clk), .rst(rst), .rx(rx1),
      .data_out(do1), .data_en(en1), .frame_err(fe1), .busy(bz1)
   );
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int en_cyc0 = -1;
   logic pen0 = 1'b0;
   logic pen1 = 1'b0;
   logic [8:0] obs0[$], obs1[$], exp0[$], exp1[$];
   logic [7:0] last0 = 8'h00;
   logic [7:0] last1 = 8'h00;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   // observed events: {1'b0, byte} for data_en, {1'b1, data_out} for frame_err
   always @(negedge clk) begin
      if (en0 | fe0) begin
         chk("strobe_excl0", {31'd0, en0 & fe0}, 0);
         obs0.push_back({fe0, do0});
      end
      if (en0) begin
         chk("en_back2back0", {31'd0, pen0}, 0);
         en_cyc0 <= cyc;
      end
      pen0 <= en0;
      if (en1 | fe1) begin
         chk("strobe_excl1", {31'd0, en1 & fe1}, 0);
         obs1.push_back({fe1, do1});
      end
      if (en1) chk("en_back2back1", {31'd0, pen1}, 0);
      pen1 <= en1;
   end
   function automatic int cpb(input int w);
      return w == 0 ? 104 : 8;
   endfunction
   task automatic setrx(input int w, input logic v);
      if (w == 0) rx0 = v;
      else rx1 = v;
   endtask
   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic expect_frame(input int w, input logic [7:0] b, input logic stop);
      if (w == 0) begin
         exp0.push_back(stop ? {1'b0, b} : {1'b1, last0});
         if (stop) last0 = b;
      end else begin
         exp1.push_back(stop ? {1'b0, b} : {1'b1, last1});
         if (stop) last1 = b;
      end
   endtask
   task automatic send_frame(input int w, input logic [7:0] b, input logic stop, input logic probe);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         setrx(w, f[i]);
         wait_n(cpb(w) / 2);
         if (probe && i > 0) chk("busy_in_frame", {31'd0, bz0}, 1);
         wait_n(cpb(w) - cpb(w) / 2);
      end
      expect_frame(w, b, stop);
   endtask
   task automatic compare(input int w, input string tag);
      wait_n(3 * cpb(w));
      if (w == 0) begin
         chk({tag, "_count"}, obs0.size(), exp0.size());
         for (int i = 0; i < obs0.size() && i < exp0.size(); i++)
            chk({tag, "_event"}, {23'd0, obs0[i]}, {23'd0, exp0[i]});
         obs0.delete();
         exp0.delete();
      end else begin
         chk({tag, "_count"}, obs1.size(), exp1.size());
         for (int i = 0; i < obs1.size() && i < exp1.size(); i++)
            chk({tag, "_event"}, {23'd0, obs1[i]}, {23'd0, exp1[i]});
         obs1.delete();
         exp1.delete();
      end
   endtask
   task automatic reset_pulse(input string tag);
      rst = 1'b1;
      wait_n(1);
      chk({tag, "_data_out0"}, {24'd0, do0}, 0);
      chk({tag, "_strobes0"}, {30'd0, en0, fe0}, 0);
      chk({tag, "_busy0"}, {31'd0, bz0}, 0);
      chk({tag, "_data_out1"}, {24'd0, do1}, 0);
      chk({tag, "_busy1"}, {31'd0, bz1}, 0);
      rst = 1'b0;
      last0 = 8'h00;
      last1 = 8'h00;
   endtask
   initial begin
      int t0, lat;
      logic [9:0] f;
      logic [7:0] b;
      logic stop;
      wait_n(3);
      reset_pulse("reset");
      wait_n(5);
      // single 'A', latency and busy
      t0 = cyc;
      send_frame(0, 8'h41, 1'b1, 1'b1);
      lat = en_cyc0 - t0;
      compare(0, "byte_41");
      chk("latency_in_range", {31'd0, lat >= 988 && lat <= 992}, 1);
      chk("busy_after_frame", {31'd0, bz0}, 0);
      // back-to-back "0A"
      send_frame(0, 8'h30, 1'b1, 1'b0);
      send_frame(0, 8'h41, 1'b1, 1'b0);
      compare(0, "back2back");
      // short low glitch is rejected at the half-bit check
      setrx(0, 1'b0);
      wait_n(30);
      setrx(0, 1'b1);
      wait_n(200);
      chk("glitch_busy", {31'd0, bz0}, 0);
      compare(0, "glitch");
      // bad stop bit, then held break, then 0x04
      send_frame(0, 8'h55, 1'b0, 1'b0);
      wait_n(3 * 104);
      chk("break_busy", {31'd0, bz0}, 1);
      chk("break_hold_data", {24'd0, do0}, 8'h41);
      setrx(0, 1'b1);
      wait_n(104);
      send_frame(0, 8'h04, 1'b1, 1'b0);
      compare(0, "break_then_eot");
      // reset during bit 4 of 0x7E, then 0x31
      f = {1'b1, 8'h7E, 1'b0};
      for (int i = 0; i < 5; i++) begin
         setrx(0, f[i]);
         wait_n(104);
      end
      setrx(0, f[5]);
      wait_n(52);
      reset_pulse("midframe_reset");
      setrx(0, 1'b1);
      wait_n(12 * 104);
      send_frame(0, 8'h31, 1'b1, 1'b0);
      compare(0, "after_reset");
      // 8 clocks per bit
      send_frame(1, 8'hA5, 1'b1, 1'b0);
      compare(1, "fast_a5");
      // random traffic, mostly good frames with occasional bad stop bits
      for (int w = 0; w < 2; w++) begin
         for (int n = 0; n < (w == 0 ? 14 : 40); n++) begin
            b = 8'($urandom);
            stop = $urandom_range(0, 7) != 0;
            send_frame(w, b, stop, 1'b0);
            if (!stop) begin
               setrx(w, 1'b1);
               wait_n(cpb(w) + $urandom_range(0, 20));
            end else wait_n($urandom_range(0, 20));
         end
         compare(w, w == 0 ? "random_slow" : "random_fast");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
